sram2rw_fifo_ctrl: RTL

- Synchronous FIFO controller that uses one external SRAM2RW-class dual-port macro (64x16) as its storage array.
- Port 1 of the macro is used only for writes and port 2 only for reads.
- Upstream producers see a valid/ready enqueue interface; downstream consumers see a valid/ready dequeue interface.
- The 1-cycle registered SRAM read latency is hidden by a 2-entry output buffer.
- The macro's CE1/CE2 are tied to `clock` at integration; the controller generates all other macro pins.

---
 rtl/sram2rw_fifo_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sram2rw_fifo_ctrl.sv
// sram2rw_fifo_ctrl
// -----------------
// Synchronous FIFO controller that stores its words in one external
// SRAM2RW-class dual-port macro. Port 1 of the macro only writes and port 2
// only reads. The macro's registered read data arrives one cycle after a read
// is issued. A 2-entry output buffer hides that latency, so the consumer sees
// one word per cycle in steady state.
//
// Ports
//   clock, reset        rising-edge clock (same net as macro CE1/CE2);
//                       asynchronous active-high reset
//   enq_valid/ready/bits  producer valid/ready interface
//   deq_valid/ready/bits  consumer valid/ready interface
//   count               total occupancy: SRAM + in-flight read + output buffer
//   mem_a1/csb1/web1/oeb1/i1   macro port 1 (write-only)
//   mem_a2/csb2/web2/oeb2      macro port 2 (read-only)
//   mem_o2              macro registered read data
module sram2rw_fifo_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_bits,
  output logic [6:0]        count,
  output logic [ADDR_W-1:0] mem_a1,
  output logic              mem_csb1,
  output logic              mem_web1,
  output logic              mem_oeb1,
  output logic [WIDTH-1:0]  mem_i1,
  output logic [ADDR_W-1:0] mem_a2,
  output logic              mem_csb2,
  output logic              mem_web2,
  output logic              mem_oeb2,
  input  logic [WIDTH-1:0]  mem_o2
);

  localparam int SC_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SC_W-1:0]   sram_cnt_q, sram_cnt_d;
  logic              rd_pend_q;
  logic [1:0]        obuf_cnt_q, obuf_cnt_d;
  logic [WIDTH-1:0]  obuf0_q, obuf0_d;
  logic [WIDTH-1:0]  obuf1_q, obuf1_d;
  logic [6:0]        count_q, count_d;

  logic              enq_fire;
  logic              deq_fire;
  logic              rd_issue;
  logic [2:0]        obuf_proj;

  // Handshakes and read-issue decision
  always_comb begin
    enq_ready = !reset && (sram_cnt_q < SC_W'(DEPTH));
    enq_fire  = enq_valid && enq_ready;
    deq_valid = (obuf_cnt_q != 2'd0);
    deq_fire  = deq_valid && deq_ready;
    // Buffer occupancy after this edge if no new read were issued. A read is
    // only issued when its returning word is guaranteed a free slot.
    obuf_proj = {1'b0, obuf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, deq_fire};
    rd_issue  = (sram_cnt_q != '0) && (obuf_proj < 3'd2);
  end

  // Macro pins: each chip-select is asserted only in a cycle that accesses.
  always_comb begin
    mem_a1   = wr_ptr_q;
    mem_csb1 = !enq_fire;
    mem_web1 = !enq_fire;
    mem_oeb1 = 1'b1;
    mem_i1   = enq_bits;
    mem_a2   = rd_ptr_q;
    mem_csb2 = !rd_issue;
    mem_web2 = 1'b1;
    mem_oeb2 = !rd_issue;
    deq_bits = obuf0_q;
    count    = count_q;
  end

  // Next-state logic
  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_W'(enq_fire);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(rd_issue);
    sram_cnt_d = sram_cnt_q + SC_W'(enq_fire) - SC_W'(rd_issue);
    // Words only move between SRAM, in-flight read and buffer, so total
    // occupancy changes by enqueues and dequeues alone.
    count_d    = count_q + 7'(enq_fire) - 7'(deq_fire);
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    obuf_cnt_d = obuf_cnt_q;
    // obuf0 is always the head; a pop shifts obuf1 forward.
    case ({rd_pend_q, deq_fire})
      2'b10: begin
        if (obuf_cnt_q == 2'd0) obuf0_d = mem_o2;
        else                    obuf1_d = mem_o2;
        obuf_cnt_d = obuf_cnt_q + 2'd1;
      end
      2'b01: begin
        obuf0_d    = obuf1_q;
        obuf_cnt_d = obuf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (obuf_cnt_q == 2'd1) begin
          obuf0_d = mem_o2;
        end else begin
          obuf0_d = obuf1_q;
          obuf1_d = mem_o2;
        end
      end
      default: ;
    endcase
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      obuf_cnt_q <= 2'd0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      rd_pend_q  <= rd_issue;
      obuf_cnt_q <= obuf_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      count_q    <= count_d;
    end
  end

endmodule
